instr_fetch: RTL

// - Instruction fetch stage in front of the program ROM: owns the PC, drives rom addr/CE/OE, returns words in order to decode.
// - Consumer handshake is valid/ready; a 2-entry skid buffer absorbs the ROM's 1-cycle read latency under backpressure.
// - Execute redirects it on taken BCOND/JCOND; decode halts it on the END idiom.

---
 rtl/instr_fetch_pkg.sv | 27 ++
 rtl/instr_fetch_skid.sv | 85 ++++++++
 rtl/instr_fetch.sv | 127 ++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e : fetch FSM encoding (BOOT / RUN / HALT)
//   RESET_PC_DEF  : default first fetch address after reset
//   credit_ok     : decides whether a normal fetch may issue without
//                   overflowing the 2-entry skid buffer
package instr_fetch_pkg;

  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  // Words that will occupy the buffer after this edge: what is stored now,
  // plus the word coming back from the ROM, minus the word decode takes.
  // A new fetch lands one cycle later, so that occupancy must leave a slot.
  function automatic logic credit_ok(input logic [1:0] count,
                                     input logic       pend,
                                     input logic       pop);
    logic [2:0] occ;
    occ = {1'b0, count} + {2'b00, pend} - {2'b00, pop};
    return (occ < 3'd2);
  endfunction

endpackage

// File: rtl/instr_fetch_skid.sv
// Two-entry shift FIFO used as the fetch skid buffer.
// Entry 0 is always the head, so dout comes straight from a register.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears data too)
//   flush         drop all entries; has priority over push
//   push, din     write a word (ignored when full unless popping)
//   pop           remove the head (ignored when empty)
//   dout          head entry
//   count         number of stored entries (0..2)
module fetch_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] e0_r;
  logic [W-1:0] e1_r;
  logic [1:0]   count_r;
  logic         pop_eff_s;
  logic         push_eff_s;

  // Qualify push/pop against the current fill level.
  always_comb begin
    pop_eff_s  = 1'b0;
    push_eff_s = 1'b0;
    if (count_r != 2'd0) begin
      pop_eff_s = pop;
    end else begin
      pop_eff_s = 1'b0;
    end
    if ((count_r != 2'd2) || pop_eff_s) begin
      push_eff_s = push;
    end else begin
      push_eff_s = 1'b0;
    end
  end

  // Storage and fill-level update; simultaneous push+pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      e0_r    <= '0;
      e1_r    <= '0;
      count_r <= 2'd0;
    end else if (flush) begin
      count_r <= 2'd0;
    end else begin
      case ({push_eff_s, pop_eff_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            e0_r <= din;
          end else begin
            e1_r <= din;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          e0_r    <= e1_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            e0_r <= din;
          end else begin
            e0_r <= e1_r;
            e1_r <= din;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign dout  = e0_r;
  assign count = count_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage in front of a synchronous program ROM.
// Owns the PC, issues ROM reads, and hands words to decode in order via a
// valid/ready handshake, using a 2-entry skid buffer for the ROM latency.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rom_ce_n, rom_oe_n, rom_addr  ROM read request (active-low enables)
//   rom_dout                      ROM data, valid the cycle after issue
//   inst_valid, inst_ready        decode handshake
//   inst, inst_pc                 instruction word and its address
//   redirect_valid, redirect_pc   taken branch/jump from execute
//   halt                          stop issuing new fetches (END idiom)
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_n,
  output logic              rom_oe_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
);

  fetch_state_e              state_r;
  fetch_state_e              state_nxt_s;
  logic [ADDR_W-1:0]         pc_r;
  logic                      pend_r;
  logic [ADDR_W-1:0]         pend_pc_r;
  logic                      issue_s;
  logic [ADDR_W-1:0]         issue_addr_s;
  logic                      pop_s;
  logic                      push_s;
  logic [1:0]                skid_count_s;
  logic [ADDR_W+DATA_W-1:0]  skid_dout_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FS_BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a redirect always (re)starts fetching.
  always_comb begin
    state_nxt_s = state_r;
    if (redirect_valid) begin
      state_nxt_s = FS_RUN;
    end else begin
      case (state_r)
        FS_BOOT: state_nxt_s = FS_RUN;
        FS_RUN:  state_nxt_s = halt ? FS_HALT : FS_RUN;
        FS_HALT: state_nxt_s = FS_HALT;
        default: state_nxt_s = FS_BOOT;
      endcase
    end
  end

  // FSM outputs: fetch issue decision and ROM request.
  // A redirect issues regardless of credit because it flushes the buffer.
  always_comb begin
    issue_s      = 1'b0;
    issue_addr_s = pc_r;
    pop_s        = inst_valid & inst_ready;
    if (rst) begin
      issue_s = 1'b0;
    end else if (redirect_valid) begin
      issue_s      = 1'b1;
      issue_addr_s = redirect_pc;
    end else if (state_r == FS_RUN) begin
      issue_s = credit_ok(skid_count_s, pend_r, pop_s);
    end else begin
      issue_s = 1'b0;
    end
  end

  assign rom_ce_n = ~issue_s;
  assign rom_oe_n = ~issue_s;
  assign rom_addr = issue_addr_s;

  // PC and in-flight tracking; the PC wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r      <= RESET_PC;
      pend_r    <= 1'b0;
      pend_pc_r <= RESET_PC;
    end else if (issue_s) begin
      pc_r      <= issue_addr_s + ADDR_W'(1);
      pend_r    <= 1'b1;
      pend_pc_r <= issue_addr_s;
    end else begin
      pend_r    <= 1'b0;
    end
  end

  // A word returning during a redirect belongs to the abandoned path.
  assign push_s = pend_r & ~redirect_valid;

  fetch_skid #(
    .W(ADDR_W + DATA_W)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push_s),
    .din   ({pend_pc_r, rom_dout}),
    .pop   (pop_s),
    .dout  (skid_dout_s),
    .count (skid_count_s)
  );

  assign inst_valid = (skid_count_s != 2'd0);
  assign inst       = skid_dout_s[DATA_W-1:0];
  assign inst_pc    = skid_dout_s[ADDR_W+DATA_W-1:DATA_W];

endmodule
